stage3_execute: RTL

Execute/writeback stage of the lab pipelined datapath: the consumer of the ID/EX pipeline register bundle. Each cycle it takes the registered operands, immediate and control fields, selects operand B, performs the ALU operation, and captures the result in an EX/WB register that drives the register-file write port. With forwarding compiled in, it resolves back-to-back read-after-write hazards. It also keeps a retired-write counter for bench and debug visibility.

---
 rtl/stage3_execute_if.sv | 30 +++
 rtl/stage3_execute.sv | 110 +++++++++++
 2 files changed

// File: rtl/stage3_execute_if.sv
// ID/EX -> EX/WB bundle for the execute/writeback stage.
// master: the upstream ID/EX register (drives operands/control, observes results).
// slave:  stage3_execute (consumes operands/control, drives the EX/WB register).
interface stage3_execute_if;
    logic [31:0] RD1_IN;
    logic [31:0] RD2_IN;
    logic [15:0] IMM_IN;
    logic        DataSource_IN;
    logic [2:0]  ALUOp_IN;
    logic [4:0]  WriteSelect_IN;
    logic        WriteEnable_IN;
    logic [4:0]  RS_IN;
    logic [4:0]  RT_IN;
    logic [31:0] WriteData_OUT;
    logic [4:0]  WriteSelect_OUT;
    logic        WriteEnable_OUT;
    logic [31:0] RetireCount_OUT;

    modport master (
        output RD1_IN, RD2_IN, IMM_IN, DataSource_IN, ALUOp_IN,
               WriteSelect_IN, WriteEnable_IN, RS_IN, RT_IN,
        input  WriteData_OUT, WriteSelect_OUT, WriteEnable_OUT, RetireCount_OUT
    );

    modport slave (
        input  RD1_IN, RD2_IN, IMM_IN, DataSource_IN, ALUOp_IN,
               WriteSelect_IN, WriteEnable_IN, RS_IN, RT_IN,
        output WriteData_OUT, WriteSelect_OUT, WriteEnable_OUT, RetireCount_OUT
    );
endinterface

// File: rtl/stage3_execute.sv
// Execute/writeback stage: operand B select, 8-op ALU, EX/WB register and
// retired-write counter. Single-cycle latency, no stall.
// Optional feature macro: STAGE3_FORWARD_EN -- when defined, the EX/WB result
// is forwarded to operand A/B on a back-to-back read-after-write hazard.
module stage3_execute (
    input  logic              clk,
    input  logic              reset,
    stage3_execute_if.slave   bus
);

    typedef enum logic [2:0] {
        OP_MOV = 3'b000,
        OP_NOT = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_OR  = 3'b100,
        OP_AND = 3'b101,
        OP_SLT = 3'b110,
        OP_XOR = 3'b111
    } alu_op_e;

    logic [31:0] wb_data;
    logic [4:0]  wb_sel;
    logic        wb_we;
    logic [31:0] retire_count;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic        write_en_next;
    logic [31:0] imm_ext;

    assign imm_ext = {{16{bus.IMM_IN[15]}}, bus.IMM_IN};

    // Register 0 is hardwired: a write to it is dropped at capture time.
    assign write_en_next = bus.WriteEnable_IN && (bus.WriteSelect_IN != 5'd0);

`ifdef STAGE3_FORWARD_EN
    logic fwd_a;
    logic fwd_b;

    // The EX/WB register is only valid to forward when it will actually be written.
    assign fwd_a = wb_we && (wb_sel != 5'd0) && (wb_sel == bus.RS_IN);
    assign fwd_b = wb_we && (wb_sel != 5'd0) && (wb_sel == bus.RT_IN);

    // Operand select with forwarding; the immediate path is never forwarded.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        op_a = bus.RD1_IN;
        op_b = bus.RD2_IN;
        if (fwd_a) begin
            op_a = wb_data;
        end
        if (bus.DataSource_IN) begin
            op_b = imm_ext;
        end else if (fwd_b) begin
            op_b = wb_data;
        end
    end
`else
    logic [9:0] unused_src;
    assign unused_src = {bus.RS_IN, bus.RT_IN};

    // Operand select without forwarding; software spaces dependent instructions.
    always_comb begin
        op_a = bus.RD1_IN;
        op_b = bus.DataSource_IN ? imm_ext : bus.RD2_IN;
    end
`endif

    // ALU: purely combinational, 32-bit wraparound, no overflow flag.
    always_comb begin
        alu_result = 32'd0;
        case (alu_op_e'(bus.ALUOp_IN))
            OP_MOV:  alu_result = op_a;
            OP_NOT:  alu_result = ~op_a;
            OP_ADD:  alu_result = op_a + op_b;
            OP_SUB:  alu_result = op_a - op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_AND:  alu_result = op_a & op_b;
            OP_SLT:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_XOR:  alu_result = op_a ^ op_b;
            default: alu_result = 32'd0;
        endcase
    end

    // EX/WB pipeline register and retired-write counter.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            wb_data      <= 32'd0;
            wb_sel       <= 5'd0;
            wb_we        <= 1'b0;
            retire_count <= 32'd0;
        end else begin
            wb_data <= alu_result;
            wb_sel  <= bus.WriteSelect_IN;
            wb_we   <= write_en_next;
            if (write_en_next) begin
                retire_count <= retire_count + 32'd1;
            end
        end
    end

    assign bus.WriteData_OUT   = wb_data;
    assign bus.WriteSelect_OUT = wb_sel;
    assign bus.WriteEnable_OUT = wb_we;
    assign bus.RetireCount_OUT = retire_count;

endmodule
